// File: rtl/branch_ctrl.sv
// Branch resolution, 2-bit BHT direction prediction, mispredict redirect and
// a stall-aware flush sequencer for the RV32I pipeline.
module branch_ctrl #(
  parameter int BHT_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        zf,
  input  logic        cf,
  input  logic        vf,
  input  logic        sf,
  output logic        redirect,
  output logic        redir_taken,
  output logic        flush,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispredict_cnt
);

  localparam int         BHT_SIZE   = 1 << BHT_IDX_W;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t                 state;
  logic [3:0]             fcnt;
  logic [1:0]             bht [BHT_SIZE];
  logic [BHT_IDX_W-1:0]   if_idx;
  logic [BHT_IDX_W-1:0]   ex_idx;
  logic                   cond;
  logic                   taken;
  logic                   resolve;
  logic                   mispredict;
  logic                   bht_we;
  logic [1:0]             bht_cur;
  logic [1:0]             bht_next;
  logic                   unused_pc_bits;

  assign if_idx = if_pc[BHT_IDX_W+1:2];
  assign ex_idx = ex_pc[BHT_IDX_W+1:2];

  assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0],
                            ex_pc[31:BHT_IDX_W+2], ex_pc[1:0]};

  // Prediction reads the pre-update table; same-cycle writes show up next cycle.
  assign pred_taken = bht[if_idx][1];

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = zf;
      3'b001:  cond = !zf;
      3'b100:  cond = (sf != vf);
      3'b101:  cond = (sf == vf);
      3'b110:  cond = !cf;
      3'b111:  cond = cf;
      default: cond = 1'b0;
    endcase
  end

  assign taken = ex_jump | (ex_branch & cond);

  // Gating with rst keeps a stray EX bundle from redirecting while in reset.
  assign resolve    = !rst & ex_valid & (ex_branch | ex_jump) & !stall & (state == IDLE);
  assign mispredict = resolve & (taken != ex_pred_taken);
  assign bht_we     = resolve & ex_branch & !ex_jump;

  assign redirect    = mispredict;
  assign redir_taken = mispredict & taken;
  assign flush       = mispredict | (state == FLUSH);

  always_comb begin
    bht_cur  = bht[ex_idx];
    bht_next = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (bht_we) begin
      bht[ex_idx] <= bht_next;
    end
  end

  // fcnt counts the remaining non-stalled flush cycles after the resolution cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fcnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict && (FLUSH_CYCLES > 1)) begin
            state <= FLUSH;
            fcnt  <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (!stall) begin
            fcnt <= fcnt - 4'd1;
            if (fcnt == 4'd1) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          fcnt  <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= 16'd0;
      mispredict_cnt <= 16'd0;
    end else begin
      if (bht_we && (branch_cnt != 16'hFFFF)) branch_cnt <= branch_cnt + 16'd1;
      if (mispredict && (mispredict_cnt != 16'hFFFF)) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule
